// File: rtl/ddr4_sref_sequencer.sv
// Static-side self-refresh sequencer: parks the DDR4 channels in self-refresh
// around partial reconfiguration, then restores them via init-skip / XSDB restore.
module ddr4_sref_sequencer #(
  parameter int NUM_CH         = 3,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int RESTORE_PULSE  = 16
) (
  input  logic              CLK_IN_125M,
  input  logic              AXI_RESET_N,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              sref_enter,
  input  logic              pr_done,
  input  logic              abort,
  output logic [NUM_CH-1:0] app_sref_req,
  input  logic [NUM_CH-1:0] app_sref_ack,
  input  logic [NUM_CH-1:0] init_calib_complete,
  output logic [NUM_CH-1:0] app_mem_init_skip,
  output logic [NUM_CH-1:0] app_xsdb_select,
  output logic [NUM_CH-1:0] app_restore_complete,
  output logic              in_sref,
  output logic              busy,
  output logic              error,
  output logic              restore_done
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int PW = $clog2(RESTORE_PULSE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTER, S_IN_SREF, S_WAIT_CALIB, S_RESTORE, S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [PW-1:0]     pulse_q, pulse_d;
  logic [NUM_CH-1:0] req_q, req_d, skip_q, skip_d, xsdb_q, xsdb_d, rc_q, rc_d;
  logic              in_sref_q, in_sref_d, busy_q, busy_d;
  logic              error_q, error_d, done_q, done_d;
  logic              timed_out, acks_ok, calib_ok;

  assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign acks_ok   = ((app_sref_ack & mask_q) == mask_q);
  assign calib_ok  = ((init_calib_complete & mask_q) == mask_q);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pulse_d = '0;
    done_d  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      mask_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (sref_enter) begin
          mask_d  = ch_enable;
          state_d = (ch_enable == '0) ? S_IN_SREF : S_ENTER;
        end
        // completion is tested before the timeout so a last-cycle ack still wins
        S_ENTER: begin
          if (acks_ok)        state_d = S_IN_SREF;
          else if (timed_out) state_d = S_ERROR;
        end
        S_IN_SREF: if (pr_done) state_d = S_WAIT_CALIB;
        S_WAIT_CALIB: begin
          if (calib_ok)       state_d = S_RESTORE;
          else if (timed_out) state_d = S_ERROR;
        end
        S_RESTORE: begin
          if (pulse_q == PW'(RESTORE_PULSE - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            pulse_d = pulse_q + 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end

    if (state_d != state_q || !(state_q == S_ENTER || state_q == S_WAIT_CALIB))
      timer_d = '0;
    else if (timer_q != '1)
      timer_d = timer_q + 1'b1;
    else
      timer_d = timer_q;

    // outputs follow the next state so they are registered yet on time
    req_d     = (state_d == S_ENTER || state_d == S_IN_SREF) ? mask_d : '0;
    skip_d    = (state_d == S_WAIT_CALIB || state_d == S_RESTORE) ? mask_d : '0;
    xsdb_d    = skip_d;
    rc_d      = (state_d == S_RESTORE) ? mask_d : '0;
    in_sref_d = (state_d == S_IN_SREF);
    busy_d    = (state_d != S_IDLE) && (state_d != S_ERROR);
    error_d   = (state_d == S_ERROR);
  end

  always_ff @(posedge CLK_IN_125M or negedge AXI_RESET_N) begin
    if (!AXI_RESET_N) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      timer_q   <= '0;
      pulse_q   <= '0;
      req_q     <= '0;
      skip_q    <= '0;
      xsdb_q    <= '0;
      rc_q      <= '0;
      in_sref_q <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      timer_q   <= timer_d;
      pulse_q   <= pulse_d;
      req_q     <= req_d;
      skip_q    <= skip_d;
      xsdb_q    <= xsdb_d;
      rc_q      <= rc_d;
      in_sref_q <= in_sref_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
      done_q    <= done_d;
    end
  end

  assign app_sref_req         = req_q;
  assign app_mem_init_skip    = skip_q;
  assign app_xsdb_select      = xsdb_q;
  assign app_restore_complete = rc_q;
  assign in_sref              = in_sref_q;
  assign busy                 = busy_q;
  assign error                = error_q;
  assign restore_done         = done_q;
endmodule
